// File: rtl/instruction_fetcher_pkg.sv
// Shared widths, opcodes, default sizes and types for the instruction fetcher.
package instruction_fetcher_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INS_WIDTH  = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int IQ_DEPTH_DEF = 4;
  localparam int BHT_BITS_DEF = 6;

  // Only two fetch states: free to issue, or one request outstanding.
  typedef enum logic {
    FETCH_IDLE,
    FETCH_WAIT_MEM
  } fetch_state_e;

  // One instruction-queue entry as handed to the dispatcher.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INS_WIDTH-1:0]  ins;
    logic                  pred_jump;
  } iq_entry_t;

endpackage

// File: rtl/instruction_fetcher_branch_predictor.sv
// Next-PC prediction: JAL always taken, B-type from a 2-bit saturating BHT,
// everything else falls through to pc+4. The BHT is trained by the ROB.
module instruction_fetcher_branch_predictor
  import instruction_fetcher_pkg::*;
#(
  parameter int BHT_BITS = BHT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  input  logic [INS_WIDTH-1:0]  lookup_ins_i,
  input  logic                  upd_en_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  output logic                  pred_jump_o,
  output logic [ADDR_WIDTH-1:0] next_pc_o
);

  localparam int BHT_ENTRIES = 1 << BHT_BITS;

  logic [1:0]            bht_q [BHT_ENTRIES];
  logic [BHT_BITS-1:0]   lookup_idx;
  logic [BHT_BITS-1:0]   upd_idx;
  logic [ADDR_WIDTH-1:0] jal_off;
  logic [ADDR_WIDTH-1:0] br_off;
  logic [6:0]            opcode;
  logic                  unused_upd_pc_bits;

  assign lookup_idx = lookup_pc_i[BHT_BITS+1:2];
  assign upd_idx    = upd_pc_i[BHT_BITS+1:2];
  assign opcode     = lookup_ins_i[6:0];

  // Sign-extended J-type and B-type immediates.
  assign jal_off = {{11{lookup_ins_i[31]}}, lookup_ins_i[31], lookup_ins_i[19:12],
                    lookup_ins_i[20], lookup_ins_i[30:21], 1'b0};
  assign br_off  = {{19{lookup_ins_i[31]}}, lookup_ins_i[31], lookup_ins_i[7],
                    lookup_ins_i[30:25], lookup_ins_i[11:8], 1'b0};

  // Only the index bits of the update PC select a counter.
  assign unused_upd_pc_bits = ^{upd_pc_i[ADDR_WIDTH-1:BHT_BITS+2], upd_pc_i[1:0]};

  // Decode the returned word and pick the predicted next fetch address.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pred_jump_o = 1'b0;
    next_pc_o   = lookup_pc_i + ADDR_WIDTH'(4);
    if (opcode == OPC_JAL) begin
      pred_jump_o = 1'b1;
      next_pc_o   = lookup_pc_i + jal_off;
    end else if (opcode == OPC_BRANCH) begin
      pred_jump_o = bht_q[lookup_idx][1];
      if (bht_q[lookup_idx][1]) next_pc_o = lookup_pc_i + br_off;
    end
  end

  // Saturating counter update from committed branches; lookup sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the BHT is reset because its power-on contents (weakly not taken) are
      // architectural; plain data storage such as the instruction queue is not.
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (rdy && upd_en_i) begin
      // NOTE: state uses non-blocking assignments so all flops sample pre-edge values.
      if (upd_taken_i && bht_q[upd_idx] != 2'b11)
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      else if (!upd_taken_i && bht_q[upd_idx] != 2'b00)
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Front-end fetch stage: single outstanding memory request, next-PC prediction,
// small instruction queue feeding the dispatcher, and ROB redirect handling.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int BHT_BITS = BHT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  mem_ready,
  input  logic [INS_WIDTH-1:0]  mem_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  dispatch_req,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INS_WIDTH-1:0]  out_ins,
  output logic                  out_pred_jump,
  input  logic                  mispredict,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  bht_update,
  input  logic [ADDR_WIDTH-1:0] bht_update_pc,
  input  logic                  bht_update_taken
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] IQ_FULL = CNT_W'(IQ_DEPTH);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  discard_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_pc_q;
  logic [INS_WIDTH-1:0]  out_ins_q;
  logic                  out_pred_q;

  iq_entry_t             iq_mem [IQ_DEPTH];
  iq_entry_t             push_entry;
  iq_entry_t             head_entry;
  logic                  push;
  logic                  pop;
  logic                  pred_jump;
  logic [ADDR_WIDTH-1:0] pred_next_pc;

  instruction_fetcher_branch_predictor #(
    .BHT_BITS (BHT_BITS)
  ) u_bp (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .lookup_pc_i  (pc_q),
    .lookup_ins_i (mem_data),
    .upd_en_i     (bht_update),
    .upd_pc_i     (bht_update_pc),
    .upd_taken_i  (bht_update_taken),
    .pred_jump_o  (pred_jump),
    .next_pc_o    (pred_next_pc)
  );

  assign push_entry = '{pc: pc_q, ins: mem_data, pred_jump: pred_jump};
  assign head_entry = iq_mem[rd_ptr_q];

  // Queue handshakes; a flush or a frozen cycle moves nothing.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (rdy && !mispredict) begin
      push = (state_q == FETCH_WAIT_MEM) && mem_ready && !discard_q;
      pop  = dispatch_req && (count_q != '0);
    end
  end

  // Queue storage; contents are only meaningful under the pointers.
  always_ff @(posedge clk) begin
    if (push) iq_mem[wr_ptr_q] <= push_entry;
  end

  // Fetch FSM, queue pointers and registered dispatcher outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ins_q   <= '0;
      out_pred_q  <= 1'b0;
    end else if (rdy) begin
      if (mispredict) begin
        pc_q        <= redirect_pc;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        count_q     <= '0;
        out_valid_q <= 1'b0;
        if (state_q == FETCH_WAIT_MEM) begin
          // The controller cannot abort: either the word arrives now and is
          // dropped, or the request is held and its data discarded later.
          if (mem_ready) begin
            state_q   <= FETCH_IDLE;
            mem_req_q <= 1'b0;
            discard_q <= 1'b0;
          end else begin
            discard_q <= 1'b1;
          end
        end
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop) begin
          rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
          out_pc_q   <= head_entry.pc;
          out_ins_q  <= head_entry.ins;
          out_pred_q <= head_entry.pred_jump;
        end
        out_valid_q <= pop;

        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase

        case (state_q)
          FETCH_IDLE: begin
            if (count_q < IQ_FULL) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_q;
              state_q    <= FETCH_WAIT_MEM;
            end
          end
          FETCH_WAIT_MEM: begin
            if (mem_ready) begin
              mem_req_q <= 1'b0;
              state_q   <= FETCH_IDLE;
              if (discard_q) discard_q <= 1'b0;
              else           pc_q      <= pred_next_pc;
            end
          end
          default: state_q <= FETCH_IDLE;
        endcase
      end
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_ins       = out_ins_q;
  assign out_pred_jump = out_pred_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: a memory responder with
// configurable latency, directed scenarios and a randomized run against a
// transaction-level reference model (instruction queue + BHT counters).
module tb_instruction_fetcher;

  localparam int IQ_DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        dispatch_req;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_pred_jump;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        bht_update;
  logic [31:0] bht_update_pc;
  logic        bht_update_taken;

  instruction_fetcher #(.IQ_DEPTH(IQ_DEPTH), .BHT_BITS(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .mem_ready        (mem_ready),
    .mem_data         (mem_data),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .dispatch_req     (dispatch_req),
    .out_valid        (out_valid),
    .out_pc           (out_pc),
    .out_ins          (out_ins),
    .out_pred_jump    (out_pred_jump),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .bht_update       (bht_update),
    .bht_update_pc    (bht_update_pc),
    .bht_update_taken (bht_update_taken)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Program memory and memory-controller behaviour.
  logic [31:0] imem [logic [31:0]];
  int   lat = 2;
  int   wait_cnt = 0;
  bit   mem_hold = 0;
  bit   rand_lat = 0;

  // Observation logs.
  logic [31:0] seen_addr [$];
  ent_t        seen_out  [$];
  logic        prev_req = 1'b0;

  // Reference model state.
  ent_t        mq [$];
  bit          m_out;
  logic [31:0] m_pc_o, m_ins_o;
  logic        m_pred_o;
  bit          m_outst, m_disc;
  logic [31:0] m_pc, m_addr;
  int          m_bht [64];

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return NOP;
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_beq(input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  // Prediction rules written directly from the ISA field layout.
  task automatic m_predict(input logic [31:0] pc, input logic [31:0] ins,
                           output logic pred, output logic [31:0] nxt);
    int off;
    pred = 1'b0;
    nxt  = pc + 32'd4;
    if (ins[6:0] == 7'b1101111) begin
      off  = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      pred = 1'b1;
      nxt  = pc + 32'(off);
    end else if (ins[6:0] == 7'b1100011) begin
      off  = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      pred = (m_bht[pc[7:2]] >= 2);
      if (pred) nxt = pc + 32'(off);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_pc_o = '0; m_ins_o = '0; m_pred_o = 1'b0;
    m_outst = 0; m_disc = 0; m_pc = '0; m_addr = '0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  // What one active clock edge does, given the inputs presented to it.
  task automatic model_edge();
    int          sz0;
    ent_t        e;
    logic        pred;
    logic [31:0] nxt;
    sz0 = mq.size();
    if (mispredict) begin
      mq.delete();
      m_out = 0;
      m_pc  = redirect_pc;
      if (m_outst) begin
        if (mem_ready) begin m_outst = 0; m_disc = 0; end
        else m_disc = 1;
      end
    end else begin
      if (dispatch_req && sz0 > 0) begin
        e = mq.pop_front();
        m_out = 1; m_pc_o = e.pc; m_ins_o = e.ins; m_pred_o = e.pred;
      end else begin
        m_out = 0;
      end
      if (!m_outst) begin
        if (sz0 < IQ_DEPTH) begin m_outst = 1; m_addr = m_pc; end
      end else if (mem_ready) begin
        m_outst = 0;
        if (m_disc) m_disc = 0;
        else begin
          m_predict(m_pc, mem_data, pred, nxt);
          mq.push_back('{pc: m_pc, ins: mem_data, pred: pred});
          m_pc = nxt;
        end
      end
    end
    if (bht_update) begin
      if (bht_update_taken && m_bht[bht_update_pc[7:2]] < 3) m_bht[bht_update_pc[7:2]]++;
      if (!bht_update_taken && m_bht[bht_update_pc[7:2]] > 0) m_bht[bht_update_pc[7:2]]--;
    end
  endtask

  // One clock: memory responds, model advances, DUT clocks, outputs logged.
  task automatic step();
    mem_ready = 1'b0;
    if (rdy && mem_req && !mem_hold) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        mem_ready = 1'b1;
        mem_data  = fetch_word(mem_addr);
        wait_cnt  = 0;
        if (rand_lat) lat = $urandom_range(1, 4);
      end
    end else if (!mem_req) begin
      wait_cnt = 0;
    end
    if (rdy) model_edge();
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    if (mem_req && !prev_req) seen_addr.push_back(mem_addr);
    prev_req = mem_req;
    if (out_valid) seen_out.push_back('{pc: out_pc, ins: out_ins, pred: out_pred_jump});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1; mem_ready = 1'b0; mem_data = '0; dispatch_req = 1'b0;
    mispredict = 1'b0; redirect_pc = '0; bht_update = 1'b0;
    bht_update_pc = '0; bht_update_taken = 1'b0;
    mem_hold = 0; lat = 2; wait_cnt = 0; rand_lat = 0;
    imem.delete(); seen_addr.delete(); seen_out.delete();
    repeat (2) @(negedge clk);
    model_reset();
    prev_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    dispatch_req = 1'b1;
    repeat (12) step();
    dispatch_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0)       begin n_mis++; $display("FAIL rst_mem_req got %0b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0)     begin n_mis++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (out_valid !== 1'b0)     begin n_mis++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0)       begin n_mis++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
    n_cmp++; if (out_ins !== 32'h0)      begin n_mis++; $display("FAIL rst_out_ins got %h want 0", out_ins); end
    n_cmp++; if (out_pred_jump !== 1'b0) begin n_mis++; $display("FAIL rst_out_pred got %0b want 0", out_pred_jump); end
    do_reset();
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_a [4];
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    repeat (40) step();
    n_cmp++; if (seen_addr.size() != 4) begin n_mis++; $display("FAIL line_req_count got %0d want 4", seen_addr.size()); end
    for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
      n_cmp++;
      if (seen_addr[i] !== exp_a[i]) begin n_mis++; $display("FAIL line_addr%0d got %h want %h", i, seen_addr[i], exp_a[i]); end
    end
    dispatch_req = 1'b1; step(); dispatch_req = 1'b0;
    n_cmp++; if (out_valid !== 1'b1)     begin n_mis++; $display("FAIL line_out_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0)       begin n_mis++; $display("FAIL line_out_pc got %h want 0", out_pc); end
    n_cmp++; if (out_ins !== NOP)        begin n_mis++; $display("FAIL line_out_ins got %h want %h", out_ins, NOP); end
    n_cmp++; if (out_pred_jump !== 1'b0) begin n_mis++; $display("FAIL line_out_pred got %0b want 0", out_pred_jump); end
    step();
    n_cmp++; if (out_valid !== 1'b0)     begin n_mis++; $display("FAIL line_valid_pulse got %0b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0)       begin n_mis++; $display("FAIL line_pc_hold got %h want 0", out_pc); end
  endtask

  task automatic test_jal();
    do_reset();
    imem[32'h8] = enc_jal(32'h10);
    dispatch_req = 1'b1;
    for (int c = 0; c < 100 && seen_addr.size() < 4; c++) step();
    repeat (10) step();
    dispatch_req = 1'b0;
    n_cmp++; if (seen_addr.size() < 4 || seen_addr[2] !== 32'h8 || seen_addr[3] !== 32'h18) begin
      n_mis++; $display("FAIL jal_target got %h want 00000018", (seen_addr.size() > 3) ? seen_addr[3] : 32'hx);
    end
    n_cmp++; if (seen_out.size() < 3) begin n_mis++; $display("FAIL jal_pops got %0d want >=3", seen_out.size()); end
    else begin
      n_cmp++; if (seen_out[2].pc !== 32'h8) begin n_mis++; $display("FAIL jal_out_pc got %h want 8", seen_out[2].pc); end
      n_cmp++; if (seen_out[2].pred !== 1'b1) begin n_mis++; $display("FAIL jal_out_pred got %0b want 1", seen_out[2].pred); end
      n_cmp++; if (seen_out[1].pred !== 1'b0) begin n_mis++; $display("FAIL jal_prev_pred got %0b want 0", seen_out[1].pred); end
    end
  endtask

  task automatic test_branch_bht();
    logic [31:0] exp_a [5];
    bit trained;
    exp_a = '{32'h0, 32'h20, 32'h24, 32'h20, 32'h18};
    trained = 0;
    do_reset();
    imem[32'h0]  = enc_jal(32'h20);
    imem[32'h20] = enc_beq(-8);
    imem[32'h24] = enc_jal(-4);
    dispatch_req = 1'b1;
    for (int c = 0; c < 150 && seen_addr.size() < 5; c++) begin
      if (!trained && seen_addr.size() == 3) begin
        trained = 1;
        bht_update = 1'b1; bht_update_pc = 32'h20; bht_update_taken = 1'b1;
        step(); step();
        bht_update = 1'b0;
      end else begin
        step();
      end
    end
    repeat (6) step();
    dispatch_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= seen_addr.size() || seen_addr[i] !== exp_a[i]) begin
        n_mis++; $display("FAIL br_addr%0d got %h want %h", i, (i < seen_addr.size()) ? seen_addr[i] : 32'hx, exp_a[i]);
      end
    end
    n_cmp++; if (seen_out.size() < 4) begin n_mis++; $display("FAIL br_pops got %0d want >=4", seen_out.size()); end
    else begin
      n_cmp++; if (seen_out[1].pc !== 32'h20 || seen_out[1].pred !== 1'b0) begin
        n_mis++; $display("FAIL br_cold got pc %h pred %0b want pc 20 pred 0", seen_out[1].pc, seen_out[1].pred); end
      n_cmp++; if (seen_out[3].pc !== 32'h20 || seen_out[3].pred !== 1'b1) begin
        n_mis++; $display("FAIL br_trained got pc %h pred %0b want pc 20 pred 1", seen_out[3].pc, seen_out[3].pred); end
    end
  endtask

  task automatic test_queue_full();
    bit hit;
    do_reset();
    repeat (40) step();
    n_cmp++; if (seen_addr.size() != 4) begin n_mis++; $display("FAIL full_req_count got %0d want 4", seen_addr.size()); end
    n_cmp++; if (mem_req !== 1'b0) begin n_mis++; $display("FAIL full_req_low got %0b want 0", mem_req); end
    dispatch_req = 1'b1; step(); dispatch_req = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_mis++; $display("FAIL full_pop got valid %0b pc %h want 1 0", out_valid, out_pc); end
    n_cmp++; if (mem_req !== 1'b0) begin n_mis++; $display("FAIL full_req_pop_cycle got %0b want 0", mem_req); end
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      n_mis++; $display("FAIL full_reissue got req %0b addr %h want 1 10", mem_req, mem_addr); end
    // Pop exactly on the cycle the memory answers, so push and pop coincide.
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      hit = mem_req && (wait_cnt + 1 >= lat);
      dispatch_req = hit;
      step();
    end
    dispatch_req = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      n_mis++; $display("FAIL full_pushpop got valid %0b pc %h want 1 4", out_valid, out_pc); end
    repeat (30) step();
    n_cmp++; if (seen_addr.size() != 6 || seen_addr[5] !== 32'h14 || mem_req !== 1'b0) begin
      n_mis++; $display("FAIL full_count_kept got reqs %0d req %0b want 6 0", seen_addr.size(), mem_req); end
  endtask

  task automatic test_mispredict();
    int stale;
    do_reset();
    for (int c = 0; c < 40 && seen_addr.size() < 2; c++) step();
    mem_hold = 1;
    mispredict = 1'b1; redirect_pc = 32'h100;
    step();
    mispredict = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL mp_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      n_mis++; $display("FAIL mp_req_held got req %0b addr %h want 1 4", mem_req, mem_addr); end
    mem_hold = 0;
    dispatch_req = 1'b1;
    repeat (30) step();
    dispatch_req = 1'b0;
    n_cmp++; if (seen_addr.size() < 3 || seen_addr[2] !== 32'h100) begin
      n_mis++; $display("FAIL mp_redirect got %h want 00000100", (seen_addr.size() > 2) ? seen_addr[2] : 32'hx); end
    n_cmp++; if (seen_out.size() == 0 || seen_out[0].pc !== 32'h100) begin
      n_mis++; $display("FAIL mp_first_pop got %h want 00000100", (seen_out.size() > 0) ? seen_out[0].pc : 32'hx); end
    stale = 0;
    foreach (seen_out[i]) if (seen_out[i].pc < 32'h100) stale++;
    n_cmp++; if (stale != 0) begin n_mis++; $display("FAIL mp_stale got %0d want 0", stale); end
  endtask

  task automatic test_freeze();
    logic        s_req, s_val;
    logic [31:0] s_addr, s_pc;
    do_reset();
    for (int c = 0; c < 40 && seen_addr.size() < 2; c++) step();
    mem_hold = 1;
    dispatch_req = 1'b1; step(); dispatch_req = 1'b0;
    s_req = mem_req; s_addr = mem_addr; s_val = out_valid; s_pc = out_pc;
    n_cmp++; if (s_val !== 1'b1 || s_pc !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h4) begin
      n_mis++; $display("FAIL frz_setup got valid %0b pc %h req %0b addr %h want 1 0 1 4", s_val, s_pc, s_req, s_addr); end
    rdy = 1'b0; mispredict = 1'b1; redirect_pc = 32'h200; dispatch_req = 1'b1;
    bht_update = 1'b1; bht_update_pc = 32'h0; bht_update_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (mem_req !== s_req || mem_addr !== s_addr) begin
        n_mis++; $display("FAIL frz_mem%0d got req %0b addr %h want %0b %h", k, mem_req, mem_addr, s_req, s_addr); end
      n_cmp++; if (out_valid !== s_val || out_pc !== s_pc) begin
        n_mis++; $display("FAIL frz_out%0d got valid %0b pc %h want %0b %h", k, out_valid, out_pc, s_val, s_pc); end
    end
    rdy = 1'b1; mispredict = 1'b0; dispatch_req = 1'b0; bht_update = 1'b0; mem_hold = 0;
    repeat (30) step();
    n_cmp++; if (seen_addr.size() < 4 || seen_addr[2] !== 32'h8 || seen_addr[3] !== 32'hC) begin
      n_mis++; $display("FAIL frz_resume got %0d reqs, third %h want 8 then C", seen_addr.size(),
                        (seen_addr.size() > 2) ? seen_addr[2] : 32'hx); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int a = 0; a < 128; a++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      imem[32'(a * 4)] = NOP;
      else if (r < 7) imem[32'(a * 4)] = enc_jal(($urandom_range(0, 31) - 16) * 4);
      else            imem[32'(a * 4)] = enc_beq(($urandom_range(0, 31) - 16) * 4);
    end
    rand_lat = 1;
    for (int c = 0; c < 800; c++) begin
      rdy              = ($urandom_range(0, 9) != 0);
      dispatch_req     = $urandom_range(0, 1);
      mispredict       = ($urandom_range(0, 29) == 0);
      redirect_pc      = 32'($urandom_range(0, 127)) << 2;
      bht_update       = ($urandom_range(0, 4) == 0);
      bht_update_pc    = 32'($urandom_range(0, 63)) << 2;
      bht_update_taken = $urandom_range(0, 1);
      step();
      n_cmp++; if (mem_req !== m_outst) begin n_mis++; $display("FAIL rnd_mem_req c%0d got %0b want %0b", c, mem_req, m_outst); end
      if (m_outst) begin
        n_cmp++; if (mem_addr !== m_addr) begin n_mis++; $display("FAIL rnd_mem_addr c%0d got %h want %h", c, mem_addr, m_addr); end
      end
      n_cmp++; if (out_valid !== m_out) begin n_mis++; $display("FAIL rnd_out_valid c%0d got %0b want %0b", c, out_valid, m_out); end
      n_cmp++; if (out_pc !== m_pc_o) begin n_mis++; $display("FAIL rnd_out_pc c%0d got %h want %h", c, out_pc, m_pc_o); end
      n_cmp++; if (out_ins !== m_ins_o) begin n_mis++; $display("FAIL rnd_out_ins c%0d got %h want %h", c, out_ins, m_ins_o); end
      n_cmp++; if (out_pred_jump !== m_pred_o) begin n_mis++; $display("FAIL rnd_out_pred c%0d got %0b want %0b", c, out_pred_jump, m_pred_o); end
    end
    rdy = 1'b1; mispredict = 1'b0; dispatch_req = 1'b0; bht_update = 1'b0; rand_lat = 0;
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_jal();
    test_branch_bht();
    test_queue_full();
    test_mispredict();
    test_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
